// File: rtl/register_file_sb.sv
// Multi-port register file with two write ports, a long-latency pending
// scoreboard, optional same-cycle write-to-read bypass and registered hazard status.
module register_file_sb #(
    parameter int unsigned Nloc   = 32,
    parameter int unsigned Dbits  = 32,
    parameter int unsigned Nread  = 2,
    parameter int unsigned Bypass = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [Nread*$clog2(Nloc)-1:0]    ReadAddr,
    output logic [Nread*Dbits-1:0]           ReadData,
    output logic [Nread-1:0]                 ReadBusy,
    input  logic                             Werf0,
    input  logic [$clog2(Nloc)-1:0]          WriteAddr0,
    input  logic [Dbits-1:0]                 WriteData0,
    input  logic                             Werf1,
    input  logic [$clog2(Nloc)-1:0]          WriteAddr1,
    input  logic [Dbits-1:0]                 WriteData1,
    input  logic                             PendSet,
    input  logic [$clog2(Nloc)-1:0]          PendAddr,
    output logic [$clog2(Nloc):0]            PendingCount,
    output logic                             WriteCollision
);

    localparam int unsigned Abits = $clog2(Nloc);
    localparam int unsigned Cbits = Abits + 1;

    logic [Dbits-1:0] rf [Nloc];
    logic [Nloc-1:0]  pend;
    logic [Nloc-1:0]  pend_nxt;
    logic [Cbits-1:0] pend_cnt_nxt;
    logic             we0_ok;
    logic             we1_ok;
    logic             collision_nxt;

    assign we0_ok        = Werf0 && (WriteAddr0 != '0);
    assign we1_ok        = Werf1 && (WriteAddr1 != '0);
    assign collision_nxt = we0_ok && we1_ok && (WriteAddr0 == WriteAddr1);

    // Next pending vector: a new issue (set) overrides a returning result (clear).
    always_comb begin
        pend_nxt = pend;
        if (we1_ok) begin
            pend_nxt[WriteAddr1] = 1'b0;
        end
        if (PendSet && (PendAddr != '0)) begin
            pend_nxt[PendAddr] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_comb begin
        pend_cnt_nxt = '0;
        for (int unsigned i = 0; i < Nloc; i++) begin
            pend_cnt_nxt = pend_cnt_nxt + Cbits'(pend_nxt[i]);
        end
    end

    // Port 0 is assigned last so it wins a same-address collision.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < Nloc; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (we1_ok) begin
                rf[WriteAddr1] <= WriteData1;
            end
            if (we0_ok) begin
                rf[WriteAddr0] <= WriteData0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend           <= '0;
            PendingCount   <= '0;
            WriteCollision <= 1'b0;
        end else begin
            pend           <= pend_nxt;
            PendingCount   <= pend_cnt_nxt;
            WriteCollision <= collision_nxt;
        end
    end

    for (genvar g = 0; g < Nread; g++) begin : g_rd
        logic [Abits-1:0] ra;
        logic [Dbits-1:0] rd;
        logic             busy;

        assign ra = ReadAddr[g*Abits +: Abits];

        // Read mux: zero register, then port 0 bypass, port 1 bypass, storage.
        always_comb begin
            rd   = rf[ra];
            busy = pend[ra];
            if (reset || (ra == '0)) begin
                rd   = '0;
                busy = 1'b0;
            end else begin
                if ((Bypass != 0) && Werf0 && (WriteAddr0 == ra)) begin
                    rd = WriteData0;
                end else if ((Bypass != 0) && Werf1 && (WriteAddr1 == ra)) begin
                    rd = WriteData1;
                end
                if ((Bypass != 0) && Werf1 && (WriteAddr1 == ra)) begin
                    busy = 1'b0;
                end
            end
        end

        assign ReadData[g*Dbits +: Dbits] = rd;
        assign ReadBusy[g]                = busy;
    end

endmodule

// File: doc/register_file_sb.md
# register_file_sb

Parametrised, scoreboarded multi-port register file for the pipelined successor of the single-cycle MIPS datapath. Provides `Nread` combinational read ports and two synchronous write ports: port 0 for single-cycle ALU results, port 1 for long-latency results such as loads and multiply/divide. A per-register pending scoreboard lets the decode stage detect reads of registers whose long-latency result has not yet returned. Optional same-cycle write-to-read bypass and a registered pending-count output are included for the hazard unit.

## Interface
- `Nloc`, default 32: number of registers; power of two, at least 2. `Abits` = $clog2(Nloc).
- `Dbits`, default 32: data width.
- `Nread`, default 2: number of read ports, 1 to 4.
- `Bypass`, default 1: 1 forwards same-cycle write data to the read ports; 0 means reads return stored contents only.
- `clock`, in, 1: system clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `ReadAddr`, in, Nread*Abits: packed read addresses; port i occupies bits [i*Abits +: Abits].
- `ReadData`, out, Nread*Dbits: packed read data, combinational.
- `ReadBusy`, out, Nread: per-port pending flag for the addressed register, combinational.
- `Werf0`, in, 1: write enable, port 0.
- `WriteAddr0`, in, Abits: write address, port 0.
- `WriteData0`, in, Dbits: write data, port 0.
- `Werf1`, in, 1: write enable, port 1; a write on this port also clears the pending bit of the target register.
- `WriteAddr1`, in, Abits: write address, port 1.
- `WriteData1`, in, Dbits: write data, port 1.
- `PendSet`, in, 1: mark register `PendAddr` as pending at the clock edge.
- `PendAddr`, in, Abits: register to mark as pending.
- `PendingCount`, out, Abits+1: registered count of pending bits currently set.
- `WriteCollision`, out, 1: registered one-cycle pulse indicating that both write ports targeted the same nonzero address in the previous cycle.

## Operation
- Register 0 reads as 0 and is never busy.
  - Writes to address 0 are ignored.
  - `PendSet` to address 0 is ignored.
- Write ports:
  - On the rising edge, `rf[WriteAddrN] <= WriteDataN` when `WerfN` is 1 and the address is nonzero.
  - If both ports write the same nonzero address, port 0's data is stored and `WriteCollision` is 1 for the following cycle.
  - Writes to different addresses both complete in the same cycle.
- Read data for port i:
  - Address 0 returns 0.
  - Otherwise, if `Bypass` is 1 and `Werf0` is active with a matching address, return `WriteData0`.
  - Otherwise, if `Bypass` is 1 and `Werf1` is active with a matching address, return `WriteData1`.
  - Otherwise return the stored `rf` entry.
- Pending bits, per register, updated at the edge:
  - `PendSet` targeting the register sets the bit.
  - A `Werf1` write to the register clears the bit.
  - When both target the same address in one cycle, the set wins, because a new operation has been issued.
  - Port 0 writes never change pending bits.
- `ReadBusy[i]` is the pending bit of `ReadAddr_i`, except that it is 0 for address 0.
  - It is also 0 when `Bypass` is 1 and `Werf1` is writing that address this cycle, because the data is forwarded.
- `PendingCount` is updated every edge to the population count of the next-state pending vector; the range is 0 to Nloc-1.

## Timing
- Reset, asynchronous:
  - All `rf` entries are 0, all pending bits are 0, `PendingCount` is 0 and `WriteCollision` is 0.
  - Outputs take their reset values while `reset` is high, regardless of `clock`.
  - A write or `PendSet` on the same edge that `reset` is asserted or still asserted is discarded.
- Write latency:
  - With `Bypass` 1, written data is visible on `ReadData` in the same cycle, combinationally.
  - With `Bypass` 0, written data is visible the cycle after the edge.
- Pending latency:
  - A bit set by `PendSet` at edge k is visible on `ReadBusy` from cycle k+1.
  - A bit cleared by `Werf1` at edge k is visible from cycle k+1, or in the same cycle through the bypass rule.
- `PendingCount` and `WriteCollision` lag their cause by exactly one edge.
- `PendSet` to an already-pending register leaves it pending; the count is unchanged and the event is not flagged.

## Test plan
- Reset in mid-operation:
  - Stimulus: write 0xDEADBEEF to r5 and set pending on r7, then assert `reset` asynchronously between edges.
  - Required response: immediately all reads are 0, `ReadBusy` is 0 and `PendingCount` is 0.
- Zero register:
  - Stimulus: `Werf0` writes 0x1234 to r0, and `PendSet` targets r0.
  - Required response: reading r0 returns 0, `ReadBusy` is 0 and `PendingCount` is 0.
- Bypass, with `Bypass`=1 and then `Bypass`=0:
  - Stimulus: `Werf1` writes 0xA5A5A5A5 to r3 while port 1 reads r3.
  - Required response with `Bypass`=1: 0xA5A5A5A5 in the same cycle.
  - Required response with `Bypass`=0: the old value in that cycle and 0xA5A5A5A5 in the next.
- Write collision:
  - Stimulus: both ports write r9 in one cycle, port 0 with 0x11 and port 1 with 0x22.
  - Required response: r9 reads 0x11 and `WriteCollision` pulses high for exactly one cycle.
- Scoreboard:
  - Stimulus: set pending on r2, r4 and r6 on consecutive edges, then apply `Werf1` to r4 together with `PendSet` on r4, then `Werf1` to r2.
  - Required response: `PendingCount` follows 1, 2, 3, 3, 2, and r4 stays busy.
- Pending count at full scale, with `Nloc`=8 and `Nread`=4:
  - Stimulus: set pending on r1 through r7 and read all four ports on pending registers.
  - Required response: `PendingCount` reaches 7 and all four `ReadBusy` bits are 1.
